// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue sitting between a multi-cycle instruction memory
// and the decode stage. It issues sequential word fetches ahead of decode and
// tags each returned instruction with its PC. Responses land in a DEPTH-entry
// FIFO that decode drains over a valid/ready handshake. A redirect flushes the
// queue, restarts fetching at the new PC and marks every in-flight response as
// stale so it is discarded on arrival.
//
// Parameters
//   DEPTH            queue entries (power of 2, >= 2)
//   MAX_OUTSTANDING  max accepted-but-unanswered memory requests (1..DEPTH)
//   RESET_PC         first fetch address after reset
//
// Ports
//   clk             clock, rising edge
//   rst_n           synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   word-aligned fetch address
//   imem_rsp_valid  response pulse, one per accepted request, in order
//   imem_rsp_data   instruction word of the response
//   redirect_valid  one-cycle flush + restart pulse
//   redirect_pc     restart address (bits [1:0] forced to 0)
//   instr_valid     head entry valid
//   instr_ready     decode consumes the head this cycle
//   instr           head instruction word
//   instr_pc        head instruction PC
//   queue_count     occupied entries
//
// Optional feature (macro FETCH_QUEUE_STATS_EN)
//   stat_stall_cycles  cycles out of reset with instr_valid=0 (saturating)
//   stat_flush_count   redirect pulses out of reset (saturating)
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         imem_req_valid,
   input  logic                         imem_req_ready,
   output logic [31:0]                  imem_req_addr,
   input  logic                         imem_rsp_valid,
   input  logic [31:0]                  imem_rsp_data,
   input  logic                         redirect_valid,
   input  logic [31:0]                  redirect_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [31:0]                  instr,
   output logic [31:0]                  instr_pc,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]                  stat_stall_cycles,
   output logic [31:0]                  stat_flush_count
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);            // entry index width
   localparam int unsigned PW = AW + 1;                   // pointer width incl. wrap bit
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [31:0]   fetch_pc_q, fetch_pc_d;    // next address to request
   logic [31:0]   rsp_pc_q,   rsp_pc_d;      // PC of the next live response
   logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [OW-1:0] outst_q,    outst_d;       // all requests still owed a response
   logic [OW-1:0] drop_q,     drop_d;        // subset of outst_q that is stale

   logic [31:0]   mem_pc_q   [DEPTH];
   logic [31:0]   mem_data_q [DEPTH];

   // ---------------------------------------------------------------------
   // Derived status
   // ---------------------------------------------------------------------
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic [PW-1:0] occupancy;
   logic          q_empty;
   logic          q_full;
   logic [OW-1:0] live_inflight;
   logic          credit_ok;
   logic          req_fire;
   logic          rsp_take;
   logic          push;
   logic          pop;
   logic [31:0]   redirect_target;

   assign wr_idx    = wr_ptr_q[AW-1:0];
   assign rd_idx    = rd_ptr_q[AW-1:0];
   assign occupancy = wr_ptr_q - rd_ptr_q;
   assign q_empty   = (wr_ptr_q == rd_ptr_q);
   assign q_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   // Only non-stale in-flight requests will need a queue slot, so they are
   // the ones reserved against free space when deciding to issue.
   assign live_inflight = outst_q - drop_q;
   assign credit_ok     = (32'(occupancy) + 32'(live_inflight)) < DEPTH;

   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   assign imem_req_valid = !rst_n && !redirect_valid
                           && (32'(outst_q) < MAX_OUTSTANDING) && credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is spurious and ignored outright.
   assign rsp_take = !rst_n && imem_rsp_valid && (outst_q != '0);

   assign pop  = !rst_n && !q_empty && instr_ready && !redirect_valid;
   // Stale responses and any response in a redirect cycle are swallowed.
   // The full guard only matters for illegal stimulus; issue credit keeps a
   // live response from ever meeting a full queue.
   assign push = rsp_take && (drop_q == '0) && !redirect_valid && (!q_full || pop);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      outst_d    = outst_q;
      drop_d     = drop_q;

      if (redirect_valid) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = redirect_target;
         rsp_pc_d   = redirect_target;
         outst_d    = outst_q - OW'(rsp_take);
         // Everything still in flight after this cycle belongs to the old
         // stream, including responses that were already marked stale.
         drop_d     = outst_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         outst_d = outst_q + OW'(req_fire) - OW'(rsp_take);
         if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   // ---------------------------------------------------------------------
   // Queue storage (no reset needed: head outputs are masked while empty)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc_q[wr_idx]   <= rsp_pc_q;
         mem_data_q[wr_idx] <= imem_rsp_data;
      end
   end

   // ---------------------------------------------------------------------
   // Head outputs: driven purely from registered state
   // ---------------------------------------------------------------------
   assign instr_valid = !q_empty;
   assign instr       = q_empty ? 32'h0 : mem_data_q[rd_idx];
   assign instr_pc    = q_empty ? 32'h0 : mem_pc_q[rd_idx];
   assign queue_count = occupancy;

`ifdef FETCH_QUEUE_STATS_EN
   // ---------------------------------------------------------------------
   // Saturating statistics counters
   // ---------------------------------------------------------------------
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (q_empty && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (redirect_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stat_stall_cycles = stall_cnt_q;
   assign stat_flush_count  = flush_cnt_q;
`endif

endmodule
